// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: 68000 CPU port, SPI byte port and the shared
// synchronous single-port RAM port. slave = arbiter side, master = environment.
interface mem_arbiter_if #(
   parameter int ADDR_BITS = 15
);
   // 68000 side
   logic                 cpu_as_n;
   logic                 cpu_rw;
   logic                 cpu_uds_n;
   logic                 cpu_lds_n;
   logic [ADDR_BITS-1:0] cpu_a;
   logic [15:0]          cpu_dout;
   logic [15:0]          cpu_din;
   logic                 cpu_dtack_n;

   // SPI slave side (byte addressed)
   logic                 spi_wr;
   logic                 spi_rd;
   logic [ADDR_BITS:0]   spi_addr;
   logic [7:0]           spi_di;
   logic [7:0]           spi_do;
   logic                 spi_done;
   logic                 spi_ovf;

   // shared RAM side
   logic [ADDR_BITS-1:0] mem_addr;
   logic [15:0]          mem_din;
   logic                 mem_we;
   logic                 mem_ub;
   logic                 mem_lb;
   logic [15:0]          mem_dout;

   modport slave (
      input  cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_a, cpu_dout,
      output cpu_din, cpu_dtack_n,
      input  spi_wr, spi_rd, spi_addr, spi_di,
      output spi_do, spi_done, spi_ovf,
      output mem_addr, mem_din, mem_we, mem_ub, mem_lb,
      input  mem_dout
   );

   modport master (
      output cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, cpu_a, cpu_dout,
      input  cpu_din, cpu_dtack_n,
      output spi_wr, spi_rd, spi_addr, spi_di,
      input  spi_do, spi_done, spi_ovf,
      input  mem_addr, mem_din, mem_we, mem_ub, mem_lb,
      output mem_dout
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter (68000 CPU, SPI byte port) onto one synchronous 16-bit RAM.
// Optional MEM_ARBITER_ROMWP_EN: CPU writes below ROM_TOP are acknowledged but dropped.
module mem_arbiter #(
   parameter int                   ADDR_BITS = 15,
   parameter logic [ADDR_BITS-1:0] ROM_TOP   = 15'h4000
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CPU_ACC,
      CPU_WAIT,
      CPU_ACK,
      SPI_ACC,
      SPI_WAIT
   } state_t;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_SPI = 1'b1;

   state_t             state;
   logic               cpu_served;
   logic               last_grant;

   // one-entry SPI request buffer
   logic               pend_vld;
   logic               pend_rd;
   logic [ADDR_BITS:0] pend_addr;
   logic [7:0]         pend_di;

   logic               cpu_req;
   logic               spi_req;
   logic               spi_pulse;
   logic               grant_cpu;
   logic               cpu_we_ok;

   always_comb begin
      cpu_req   = ~bus.cpu_as_n & (~bus.cpu_uds_n | ~bus.cpu_lds_n) & ~cpu_served;
      spi_req   = pend_vld;
      spi_pulse = bus.spi_wr | bus.spi_rd;
      grant_cpu = cpu_req & (~spi_req | (last_grant == GNT_SPI));
   end

`ifdef MEM_ARBITER_ROMWP_EN
   assign cpu_we_ok = ~bus.cpu_rw & (bus.cpu_a >= ROM_TOP);
`else
   assign cpu_we_ok = ~bus.cpu_rw;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         cpu_served      <= 1'b0;
         last_grant      <= GNT_CPU;
         pend_vld        <= 1'b0;
         pend_rd         <= 1'b0;
         pend_addr       <= '0;
         pend_di         <= '0;
         bus.cpu_dtack_n <= 1'b1;
         bus.cpu_din     <= '0;
         bus.spi_do      <= '0;
         bus.spi_done    <= 1'b0;
         bus.spi_ovf     <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_ub      <= 1'b0;
         bus.mem_lb      <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_din     <= '0;
      end else begin
         bus.spi_done <= 1'b0;
         bus.mem_we   <= 1'b0;

         // A bus cycle counts as new only after AS has been seen high.
         if (bus.cpu_as_n)
            cpu_served <= 1'b0;

         // The entry is freed on the same edge spi_done rises, so a pulse
         // in the done cycle finds it empty and is accepted.
         if (spi_pulse) begin
            if (pend_vld) begin
               bus.spi_ovf <= 1'b1;
            end else begin
               pend_vld  <= 1'b1;
               pend_rd   <= bus.spi_rd;
               pend_addr <= bus.spi_addr;
               pend_di   <= bus.spi_di;
            end
         end

         case (state)
            IDLE: begin
               // last_grant holds the winner of the latest tie, so
               // back-to-back ties alternate between the two masters.
               if (cpu_req && spi_req)
                  last_grant <= grant_cpu ? GNT_CPU : GNT_SPI;
               if (grant_cpu) begin
                  state        <= CPU_ACC;
                  cpu_served   <= 1'b1;
                  bus.mem_addr <= bus.cpu_a;
                  bus.mem_ub   <= ~bus.cpu_uds_n;
                  bus.mem_lb   <= ~bus.cpu_lds_n;
                  bus.mem_we   <= cpu_we_ok;
                  if (!bus.cpu_rw)
                     bus.mem_din <= bus.cpu_dout;
               end else if (spi_req) begin
                  state        <= SPI_ACC;
                  bus.mem_addr <= pend_addr[ADDR_BITS:1];
                  bus.mem_ub   <= ~pend_addr[0];
                  bus.mem_lb   <= pend_addr[0];
                  bus.mem_din  <= {pend_di, pend_di};
                  bus.mem_we   <= ~pend_rd;
               end
            end

            CPU_ACC: begin
               bus.mem_ub <= 1'b0;
               bus.mem_lb <= 1'b0;
               if (bus.cpu_rw) begin
                  state <= CPU_WAIT;
               end else begin
                  state           <= CPU_ACK;
                  bus.cpu_dtack_n <= 1'b0;
               end
            end

            CPU_WAIT: begin
               state           <= CPU_ACK;
               bus.cpu_din     <= bus.mem_dout;
               bus.cpu_dtack_n <= 1'b0;
            end

            CPU_ACK: begin
               if (bus.cpu_as_n) begin
                  state           <= IDLE;
                  bus.cpu_dtack_n <= 1'b1;
               end
            end

            SPI_ACC: begin
               bus.mem_ub <= 1'b0;
               bus.mem_lb <= 1'b0;
               if (pend_rd) begin
                  state <= SPI_WAIT;
               end else begin
                  state        <= IDLE;
                  bus.spi_done <= 1'b1;
                  pend_vld     <= 1'b0;
               end
            end

            SPI_WAIT: begin
               state        <= IDLE;
               bus.spi_do   <= pend_addr[0] ? bus.mem_dout[7:0] : bus.mem_dout[15:8];
               bus.spi_done <= 1'b1;
               pend_vld     <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
